// File: rtl/gray_counter_ctrl.sv
// gray_counter_ctrl: debounced run/pause/step/clear controller that issues one-cycle
// advance and clear strobes to the Gray LED counter.
module gray_counter_ctrl #(
    parameter int DEB_CYCLES = 1000000,
    parameter int DEB_W      = $clog2(DEB_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_run,
    input  logic       btn_step,
    input  logic       btn_clr,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       run_led,
    output logic [1:0] mode
);
    typedef enum logic [1:0] {PAUSE = 2'b00, RUN = 2'b01, CLR = 2'b10} state_t;
    state_t           state_q, state_d;
    logic [2:0]       btn, s1_q, s2_q, db_q, db_d, dbd_q, evt;
    logic [DEB_W-1:0] cnt_q [3];
    logic [DEB_W-1:0] cnt_d [3];
    logic             cnt_en_q, cnt_en_d, cnt_clr_q, run_led_q;
    // bit 0 run, bit 1 step, bit 2 clear
    assign btn = {btn_clr, btn_step, btn_run};
    assign evt = db_q & ~dbd_q;
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) db_d[i] = s2_q[i];
                else cnt_d[i] = cnt_q[i] + DEB_W'(1);
            end
        end
    end
    always_comb begin
        state_d  = state_q;
        cnt_en_d = 1'b0;
        case (state_q)
            PAUSE: begin
                if (evt[2]) state_d = CLR;
                else if (evt[0]) state_d = RUN;
                else cnt_en_d = evt[1];
            end
            RUN: begin
                if (evt[2]) state_d = CLR;
                else if (evt[0]) state_d = PAUSE;
                else cnt_en_d = tick;
            end
            default: state_d = PAUSE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            db_q      <= '0;
            dbd_q     <= '0;
            cnt_q     <= '{default: '0};
            state_q   <= PAUSE;
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
            run_led_q <= 1'b0;
        end else begin
            s1_q      <= btn;
            s2_q      <= s1_q;
            db_q      <= db_d;
            dbd_q     <= db_q;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            cnt_en_q  <= cnt_en_d;
            cnt_clr_q <= state_d == CLR;
            run_led_q <= state_d == RUN;
        end
    end
    assign cnt_en  = cnt_en_q;
    assign cnt_clr = cnt_clr_q;
    assign run_led = run_led_q;
    assign mode    = state_q;
endmodule

// File: tb/tb_gray_counter_ctrl.sv
// tb_gray_counter_ctrl: directed checks of debounce latency, glitch rejection,
// FSM transitions, priority and asynchronous reset with DEB_CYCLES=4.
module tb_gray_counter_ctrl;
    logic       clk = 1'b0, rst = 1'b1, tick = 1'b0;
    logic [2:0] btn = '0;
    logic       cnt_en, cnt_clr, run_led;
    logic [1:0] mode;
    int         checks = 0, errors = 0, en_n = 0, both_n = 0, base;

    gray_counter_ctrl #(.DEB_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .btn_run(btn[0]), .btn_step(btn[1]), .btn_clr(btn[2]),
        .cnt_en(cnt_en), .cnt_clr(cnt_clr), .run_led(run_led), .mode(mode)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cnt_en) en_n <= en_n + 1;
        if (cnt_en && cnt_clr) both_n <= both_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // press at a negedge, hold, release, then let the release debounce out
    task automatic press(input int b, input int hold);
        btn[b] = 1'b1;
        cyc(hold);
        btn[b] = 1'b0;
        cyc(10);
    endtask

    initial begin
        cyc(1);
        chk("rst_mode", mode, 2'b00);
        chk("rst_en", cnt_en, 0);
        chk("rst_clr", cnt_clr, 0);
        chk("rst_led", run_led, 0);
        rst = 1'b0;
        cyc(2);
        // single step: strobe exactly at the 7th negedge after the press
        btn[1] = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            if (i == 10) btn[1] = 1'b0;
            chk($sformatf("step_en_%0d", i), cnt_en, i == 7);
        end
        chk("step_mode", mode, 2'b00);
        chk("step_total", en_n, 1);
        // run and count ticks
        press(0, 8);
        chk("run_mode", mode, 2'b01);
        chk("run_led", run_led, 1);
        base = en_n;
        for (int k = 0; k < 3; k++) begin
            tick = 1'b1;
            cyc(1);
            tick = 1'b0;
            chk($sformatf("tick_en_%0d", k), cnt_en, 1);
            cyc(1);
            chk($sformatf("tick_off_%0d", k), cnt_en, 0);
            cyc(2);
        end
        chk("tick_total", en_n - base, 3);
        press(0, 8);
        chk("pause_mode", mode, 2'b00);
        chk("pause_led", run_led, 0);
        // glitch rejection
        btn[0] = 1'b1;
        cyc(3);
        btn[0] = 1'b0;
        cyc(10);
        chk("glitch_mode", mode, 2'b00);
        // bounce then steady high: one toggle only
        for (int i = 0; i < 4; i++) begin
            btn[0] = ~btn[0];
            cyc(1);
        end
        press(0, 10);
        chk("bounce_mode", mode, 2'b01);
        // clr and run on the same cycle while running
        btn[0] = 1'b1;
        btn[2] = 1'b1;
        cyc(7);
        chk("prio_mode", mode, 2'b10);
        chk("prio_clr", cnt_clr, 1);
        cyc(1);
        chk("prio_after", mode, 2'b00);
        chk("prio_clr_off", cnt_clr, 0);
        btn[0] = 1'b0;
        btn[2] = 1'b0;
        cyc(10);
        // tick coincident with run event in RUN is dropped
        press(0, 8);
        chk("run2_mode", mode, 2'b01);
        base = en_n;
        btn[0] = 1'b1;
        cyc(6);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        chk("coinc_mode", mode, 2'b00);
        chk("coinc_en", cnt_en, 0);
        cyc(1);
        btn[0] = 1'b0;
        cyc(10);
        chk("coinc_total", en_n - base, 0);
        // clear from PAUSE with a step event landing in the CLR cycle
        base = en_n;
        btn[2] = 1'b1;
        cyc(1);
        btn[1] = 1'b1;
        cyc(6);
        chk("clrp_mode", mode, 2'b10);
        chk("clrp_clr", cnt_clr, 1);
        cyc(1);
        chk("clrp_after", mode, 2'b00);
        chk("clrp_en", cnt_en, 0);
        btn[2] = 1'b0;
        btn[1] = 1'b0;
        cyc(10);
        chk("clrp_total", en_n - base, 0);
        // asynchronous reset in RUN with tick strobe active
        press(0, 8);
        chk("run3_mode", mode, 2'b01);
        tick = 1'b1;
        @(posedge clk);
        #1;
        chk("pre_rst_en", cnt_en, 1);
        rst = 1'b1;
        #1;
        chk("arst_mode", mode, 2'b00);
        chk("arst_en", cnt_en, 0);
        chk("arst_led", run_led, 0);
        cyc(1);
        rst = 1'b0;
        base = en_n;
        cyc(5);
        tick = 1'b0;
        cyc(1);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(3);
        chk("idle_en_total", en_n - base, 0);
        chk("idle_mode", mode, 2'b00);
        chk("exclusive", both_n, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
